compose_power: RTL

Sequential inverse of the hypercube power-decomposition path. It accepts a stream of dimension indices `n` over a valid/ready handshake and rebuilds a node address by toggling bit `2^n` of a base address for each accepted index. It also counts hops and flags malformed streams. It sits at the NOC injection side, turning a per-hop dimension list back into the destination node ID for header generation and checking.

---
 rtl/compose_power_pkg.sv | 14 +
 rtl/compose_power_dim.sv | 24 ++
 rtl/compose_power.sv | 121 ++++++++++++
 3 files changed

// File: rtl/compose_power_pkg.sv
// Shared types and default sizes for the hypercube path-composition block.
package compose_power_pkg;

  localparam int unsigned WIDTH_DEF = 5;  // node address width
  localparam int unsigned NW_DEF    = 3;  // dimension index width, clog2(WIDTH)
  localparam int unsigned HW_DEF    = 3;  // hop counter width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/compose_power_dim.sv
// Dimension index to one-hot toggle mask, flagging indices beyond the cube.
module dim_decode
  import compose_power_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned NW    = NW_DEF
) (
  input  logic [NW-1:0]    n_i,
  output logic [WIDTH-1:0] onehot_o,
  output logic             range_err_o
);

  // Index is out of range when it names a dimension the cube does not have.
  assign range_err_o = (32'(n_i) >= WIDTH);

  // One-hot decode; all-zero for out-of-range indices.
  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (32'(n_i) == i) onehot_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/compose_power.sv
// Rebuilds a destination node address from a stream of hypercube dimension
// indices, counting hops and flagging malformed streams.
module compose_power
  import compose_power_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned NW    = NW_DEF,
  parameter int unsigned HW    = HW_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] base_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [NW-1:0]    n_i,
  input  logic             last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] num_o,
  output logic [HW-1:0]    hops_o,
  output logic             err_o
);

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [HW-1:0]    hops_q, hops_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] onehot;
  logic             range_err;
  logic             beat;

  dim_decode #(
    .WIDTH (WIDTH),
    .NW    (NW)
  ) u_dim_decode (
    .n_i         (n_i),
    .onehot_o    (onehot),
    .range_err_o (range_err)
  );

  assign in_ready_o  = (state_q != ST_DONE);
  assign beat        = in_valid_i && in_ready_o;
  assign out_valid_o = out_valid_q;
  assign num_o       = acc_q;
  assign hops_o      = hops_q;
  assign err_o       = err_q;

  // Next accumulator/mask/hops/err; first beat reloads from base_i.
  always_comb begin
    acc_d  = acc_q;
    mask_d = mask_q;
    hops_d = hops_q;
    err_d  = err_q;
    if (beat) begin
      if (state_q == ST_IDLE) begin
        acc_d  = base_i;
        mask_d = '0;
        hops_d = '0;
        err_d  = 1'b0;
        if (range_err) begin
          err_d = 1'b1;
        end else begin
          acc_d  = base_i ^ onehot;
          mask_d = onehot;
          hops_d = HW'(1);
        end
      end else if (range_err) begin
        err_d = 1'b1;
      end else begin
        acc_d  = acc_q ^ onehot;
        mask_d = mask_q | onehot;
        if ((mask_q & onehot) != '0) err_d = 1'b1;
        // Saturated counter stays put and marks the stream as malformed.
        if (hops_q == '1) err_d = 1'b1;
        else              hops_d = hops_q + HW'(1);
      end
    end
  end

  // Stream FSM plus result registers, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      mask_q      <= '0;
      hops_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      mask_q <= mask_d;
      hops_q <= hops_d;
      err_q  <= err_d;
      case (state_q)
        ST_IDLE, ST_ACCUM: begin
          if (beat) begin
            if (last_i) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ST_ACCUM;
            end
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
